// File: rtl/fsm_pair_encoder.sv
// fsm_pair_encoder
// Turns a request for N "one-pairs" into a serial din_out stream that drives
// a downstream three-state pulse FSM (idle/s0/s1).
//
// One pair is: ONE_A (1 cycle), GAP_A (GAP cycles), ONE_B (1 cycle),
// GAP_B (GAP cycles). The downstream FSM arms on the first one and
// pulses on the second one, so every pair yields exactly one dout pulse.
//
// Abort is sticky and only acts on a pair boundary, so a pair is never
// cut in half. An abort that coincides with the handshake itself ends
// the request before any pair is started.
module fsm_pair_encoder #(
   parameter int CNT_W = 8,
   parameter int GAP   = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   input  logic [CNT_W-1:0] req_count,
   output logic             req_ready,
   input  logic             abort,
   output logic             din_out,
   output logic             busy,
   output logic             done,
   output logic             aborted,
   output logic [CNT_W-1:0] sent_cnt
);

   typedef enum logic [2:0] {
      IDLE,
      ONE_A,
      GAP_A,
      ONE_B,
      GAP_B,
      DONE
   } state_t;

   // With GAP=0 the gap states are never entered.
   localparam bit             HAS_GAP  = (GAP > 0);
   localparam logic [3:0]     GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state;
   state_t           state_nx;
   logic [CNT_W-1:0] remaining;
   logic [CNT_W-1:0] remaining_nx;
   logic [CNT_W-1:0] sent;
   logic [CNT_W-1:0] sent_nx;
   logic [3:0]       gap_cnt;
   logic [3:0]       gap_cnt_nx;
   logic             abort_flag;
   logic             abort_flag_nx;

   // State and datapath registers; reset clears everything immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         remaining  <= '0;
         sent       <= '0;
         gap_cnt    <= '0;
         abort_flag <= 1'b0;
      end else begin
         state      <= state_nx;
         remaining  <= remaining_nx;
         sent       <= sent_nx;
         gap_cnt    <= gap_cnt_nx;
         abort_flag <= abort_flag_nx;
      end
   end

   // Next-state logic: pair sequencing, counters and the sticky abort flag.
   always_comb begin
      state_nx      = state;
      remaining_nx  = remaining;
      sent_nx       = sent;
      gap_cnt_nx    = gap_cnt;
      abort_flag_nx = abort_flag;

      case (state)
         IDLE: begin
            if (req_valid) begin
               remaining_nx  = req_count;
               sent_nx       = '0;
               gap_cnt_nx    = '0;
               abort_flag_nx = abort;
               if ((req_count == '0) || abort) begin
                  state_nx = DONE;
               end else begin
                  state_nx = ONE_A;
               end
            end
         end

         ONE_A: begin
            gap_cnt_nx = '0;
            if (HAS_GAP) begin
               state_nx = GAP_A;
            end else begin
               state_nx = ONE_B;
            end
         end

         GAP_A: begin
            if (gap_cnt == GAP_LAST) begin
               gap_cnt_nx = '0;
               state_nx   = ONE_B;
            end else begin
               gap_cnt_nx = gap_cnt + 4'd1;
            end
         end

         ONE_B: begin
            sent_nx      = sent + CNT_ONE;
            remaining_nx = remaining - CNT_ONE;
            gap_cnt_nx   = '0;
            if (HAS_GAP) begin
               state_nx = GAP_B;
            end else if ((remaining == CNT_ONE) || abort_flag || abort) begin
               state_nx = DONE;
            end else begin
               state_nx = ONE_A;
            end
         end

         GAP_B: begin
            if (gap_cnt == GAP_LAST) begin
               gap_cnt_nx = '0;
               if ((remaining == '0) || abort_flag || abort) begin
                  state_nx = DONE;
               end else begin
                  state_nx = ONE_A;
               end
            end else begin
               gap_cnt_nx = gap_cnt + 4'd1;
            end
         end

         DONE: begin
            state_nx = IDLE;
         end

         default: begin
            state_nx = IDLE;
         end
      endcase

      if ((state != IDLE) && (state != DONE) && abort) begin
         abort_flag_nx = 1'b1;
      end
   end

   // Moore outputs decoded straight from the state register.
   always_comb begin
      req_ready = (state == IDLE);
      din_out   = (state == ONE_A) || (state == ONE_B);
      busy      = (state != IDLE);
      done      = (state == DONE);
      aborted   = (state == DONE) && abort_flag;
      sent_cnt  = sent;
   end

endmodule

// File: tb/tb_fsm_pair_encoder.sv
// tb_fsm_pair_encoder
// Drives two encoders (GAP=1 and GAP=0) with a shared clock and reset.
// Completion results of the GAP=1 instance are predicted into a queue when
// a request is issued and compared when done appears. A small model of the
// downstream pulse FSM checks where dout pulses land.
module tb_fsm_pair_encoder;

   localparam int CNT_W = 8;

   typedef struct {
      int sent;
      bit abrt;
      int cycle;
   } exp_t;

   typedef enum logic [1:0] {DS_IDLE, DS_S0, DS_S1} ds_t;

   logic             clk;
   logic             rst_n;

   logic             req_valid;
   logic [CNT_W-1:0] req_count;
   logic             req_ready;
   logic             abort;
   logic             din_out;
   logic             busy;
   logic             done;
   logic             aborted;
   logic [CNT_W-1:0] sent_cnt;

   logic             req_valid0;
   logic [CNT_W-1:0] req_count0;
   logic             req_ready0;
   logic             abort0;
   logic             din_out0;
   logic             busy0;
   logic             done0;
   logic             aborted0;
   logic [CNT_W-1:0] sent_cnt0;

   ds_t  ds;
   ds_t  ds0;
   logic ds_dout;
   logic ds0_dout;

   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;
   exp_t sb[$];
   exp_t mon_e;

   fsm_pair_encoder #(.CNT_W(CNT_W), .GAP(1)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_count (req_count),
      .req_ready (req_ready),
      .abort     (abort),
      .din_out   (din_out),
      .busy      (busy),
      .done      (done),
      .aborted   (aborted),
      .sent_cnt  (sent_cnt)
   );

   fsm_pair_encoder #(.CNT_W(CNT_W), .GAP(0)) dut0 (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid0),
      .req_count (req_count0),
      .req_ready (req_ready0),
      .abort     (abort0),
      .din_out   (din_out0),
      .busy      (busy0),
      .done      (done0),
      .aborted   (aborted0),
      .sent_cnt  (sent_cnt0)
   );

   // Free-running clock, 10 time units per cycle.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle index: during cycle k (between edges k and k+1) cyc equals k.
   always @(posedge clk) cyc <= cyc + 1;

   // Downstream pulse FSMs: arm on a one, pulse on the next one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ds  <= DS_IDLE;
         ds0 <= DS_IDLE;
      end else begin
         case (ds)
            DS_IDLE: if (!din_out) ds <= DS_S0;
            DS_S0:   if (din_out)  ds <= DS_S1;
            DS_S1:   if (din_out)  ds <= DS_S0;
            default: ds <= DS_IDLE;
         endcase
         case (ds0)
            DS_IDLE: if (!din_out0) ds0 <= DS_S0;
            DS_S0:   if (din_out0)  ds0 <= DS_S1;
            DS_S1:   if (din_out0)  ds0 <= DS_S0;
            default: ds0 <= DS_IDLE;
         endcase
      end
   end

   assign ds_dout  = (ds == DS_S1) && din_out;
   assign ds0_dout = (ds0 == DS_S1) && din_out0;

   // Completion monitor for the GAP=1 instance: every done is matched
   // against the oldest predicted result.
   always @(negedge clk) begin
      if (rst_n && done) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("[TB] FAIL done_unexpected: got done=1 at cycle %0d, required no done", cyc);
         end else begin
            mon_e = sb.pop_front();
            if (sent_cnt !== CNT_W'(mon_e.sent) || aborted !== mon_e.abrt || cyc != mon_e.cycle) begin
               errors++;
               $display("[TB] FAIL done_result: got sent_cnt=%0d aborted=%0b cycle=%0d, required sent_cnt=%0d aborted=%0b cycle=%0d",
                        sent_cnt, aborted, cyc, mon_e.sent, mon_e.abrt, mon_e.cycle);
            end
         end
      end
   end

   // Issue one request on the GAP=1 instance at the current negedge and
   // predict its completion; returns at the negedge after the handshake.
   task automatic start_req(input int count, input bit ab, input int exp_sent,
                            input bit exp_ab, input int done_off, output int t);
      exp_t e;
      req_valid = 1'b1;
      req_count = CNT_W'(count);
      abort     = ab;
      t         = cyc;
      e.sent    = exp_sent;
      e.abrt    = exp_ab;
      e.cycle   = t + done_off;
      sb.push_back(e);
      @(negedge clk);
      req_valid = 1'b0;
      abort     = 1'b0;
   endtask

   task automatic test_reset;
      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_count  = '0;
      abort      = 1'b0;
      req_valid0 = 1'b0;
      req_count0 = '0;
      abort0     = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({req_ready, din_out, busy, done, aborted} !== 5'b10000) begin
         errors++;
         $display("[TB] FAIL reset_flags: got ready,din,busy,done,aborted=%b, required 10000",
                  {req_ready, din_out, busy, done, aborted});
      end
      checks++;
      if (sent_cnt !== '0 || sent_cnt0 !== '0) begin
         errors++;
         $display("[TB] FAIL reset_sent: got %0d/%0d, required 0/0", sent_cnt, sent_cnt0);
      end
      checks++;
      if ({req_ready0, din_out0, busy0, done0, aborted0} !== 5'b10000) begin
         errors++;
         $display("[TB] FAIL reset_flags0: got %b, required 10000",
                  {req_ready0, din_out0, busy0, done0, aborted0});
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (din_out !== 1'b0 || req_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL post_reset: got din_out=%b req_ready=%b, required 0 1", din_out, req_ready);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_basic;
      int t;
      bit exp_din;
      bit exp_pulse;
      start_req(3, 1'b0, 3, 1'b0, 13, t);
      for (int off = 1; off <= 14; off++) begin
         exp_din   = (off <= 11) && (off % 2 == 1);
         exp_pulse = (off == 3) || (off == 7) || (off == 11);
         checks++;
         if (din_out !== exp_din) begin
            errors++;
            $display("[TB] FAIL basic_din T+%0d: got %b, required %b", off, din_out, exp_din);
         end
         checks++;
         if (ds_dout !== exp_pulse) begin
            errors++;
            $display("[TB] FAIL basic_dout T+%0d: got %b, required %b", off, ds_dout, exp_pulse);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_zero_count;
      int t;
      start_req(0, 1'b0, 0, 1'b0, 1, t);
      checks++;
      if (din_out !== 1'b0 || req_ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL zero_T1: got din_out=%b req_ready=%b, required 0 0", din_out, req_ready);
      end
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1 || din_out !== 1'b0) begin
         errors++;
         $display("[TB] FAIL zero_T2: got req_ready=%b din_out=%b, required 1 0", req_ready, din_out);
      end
      @(negedge clk);
   endtask

   task automatic test_abort_mid;
      int t;
      start_req(5, 1'b0, 2, 1'b1, 9, t);
      repeat (5) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      checks++;
      if (din_out !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL abort_pair_completes: got din_out=%b busy=%b at T+7, required 1 1", din_out, busy);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || req_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL abort_idle: got busy=%b req_ready=%b at T+10, required 0 1", busy, req_ready);
      end
   endtask

   task automatic test_abort_handshake;
      int t;
      start_req(4, 1'b1, 0, 1'b1, 1, t);
      checks++;
      if (din_out !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL abort_hs: got din_out=%b busy=%b at T+1, required 0 1", din_out, busy);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_abort_last_and_idle;
      int t;
      start_req(1, 1'b0, 1, 1'b1, 5, t);
      repeat (3) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      start_req(1, 1'b0, 1, 1'b0, 5, t);
      repeat (5) @(negedge clk);
   endtask

   task automatic test_reset_mid;
      int t;
      start_req(3, 1'b0, 3, 1'b0, 13, t);
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (din_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_async: got din_out=%b busy=%b done=%b before edge, required 0 0 0",
                  din_out, busy, done);
      end
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_release: got req_ready=%b busy=%b, required 1 0", req_ready, busy);
      end
      start_req(1, 1'b0, 1, 1'b0, 5, t);
      repeat (5) @(negedge clk);
   endtask

   task automatic test_back_to_back;
      int   t;
      exp_t e;
      req_valid = 1'b1;
      req_count = CNT_W'(1);
      t         = cyc;
      e.sent = 1; e.abrt = 1'b0; e.cycle = t + 5;
      sb.push_back(e);
      e.sent = 2; e.abrt = 1'b0; e.cycle = t + 6 + 1 + 8;
      sb.push_back(e);
      @(negedge clk);
      req_count = CNT_W'(2);
      repeat (4) @(negedge clk);
      checks++;
      if (req_ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL b2b_ready_done: got %b at T+5, required 0", req_ready);
      end
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL b2b_ready_idle: got %b at T+6, required 1", req_ready);
      end
      @(negedge clk);
      req_valid = 1'b0;
      checks++;
      if (din_out !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL b2b_second_start: got din_out=%b busy=%b at T+7, required 1 1", din_out, busy);
      end
      repeat (9) @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL b2b_end: got busy=%b at T+16, required 0", busy);
      end
   endtask

   task automatic test_gap0;
      bit exp_din;
      bit exp_pulse;
      bit exp_done;
      req_valid0 = 1'b1;
      req_count0 = CNT_W'(2);
      @(negedge clk);
      req_valid0 = 1'b0;
      for (int off = 1; off <= 6; off++) begin
         exp_din   = (off <= 4);
         exp_pulse = (off == 2) || (off == 4);
         exp_done  = (off == 5);
         checks++;
         if (din_out0 !== exp_din || ds0_dout !== exp_pulse || done0 !== exp_done) begin
            errors++;
            $display("[TB] FAIL gap0 T+%0d: got din=%b dout=%b done=%b, required %b %b %b",
                     off, din_out0, ds0_dout, done0, exp_din, exp_pulse, exp_done);
         end
         if (off == 5) begin
            checks++;
            if (sent_cnt0 !== CNT_W'(2) || aborted0 !== 1'b0) begin
               errors++;
               $display("[TB] FAIL gap0_result: got sent_cnt=%0d aborted=%b, required 2 0", sent_cnt0, aborted0);
            end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_max_count;
      int t;
      int done_at;
      t          = cyc;
      done_at    = -1;
      req_valid0 = 1'b1;
      req_count0 = '1;
      @(negedge clk);
      req_valid0 = 1'b0;
      for (int k = 0; k < 600 && done_at < 0; k++) begin
         if (done0) begin
            done_at = cyc;
            checks++;
            if (sent_cnt0 !== '1 || aborted0 !== 1'b0) begin
               errors++;
               $display("[TB] FAIL max_result: got sent_cnt=%0d aborted=%b, required 255 0", sent_cnt0, aborted0);
            end
         end else begin
            @(negedge clk);
         end
      end
      checks++;
      if (done_at != t + 1 + 255 * 2) begin
         errors++;
         $display("[TB] FAIL max_done_cycle: got %0d, required %0d", done_at, t + 1 + 255 * 2);
      end
      repeat (2) @(negedge clk);
   endtask

   // Bound on total run time in case the design stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no finish by time limit, required finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Test sequence.
   initial begin
      test_reset();
      test_basic();
      test_zero_count();
      test_abort_mid();
      test_abort_handshake();
      test_abort_last_and_idle();
      test_reset_mid();
      test_back_to_back();
      test_gap0();
      test_max_count();
      repeat (3) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("[TB] FAIL pending_done: got %0d outstanding, required 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
